// File: rtl/regfile_pkg.sv
// Shared definitions for the sequential address decoder: default address
// width, FSM state encoding and the debug snapshot exposed by the top.
package regfile_pkg;

  // Default address width of the decoder (legal range 1..6).
  localparam int ADDR_W_DEFAULT = 3;

  // Widest address the decoder supports; debug fields are sized to this.
  localparam int ADDR_W_MAX = 6;

  // Controller states: IDLE serves direct requests, SCAN walks a range.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Snapshot of the controller internals, zero-extended to ADDR_W_MAX.
  typedef struct packed {
    state_t                state;
    logic [ADDR_W_MAX-1:0] cnt;
    logic [ADDR_W_MAX-1:0] first;
    logic [ADDR_W_MAX-1:0] last;
  } dbg_t;

endpackage

// File: rtl/onehot_enc.sv
// Combinational binary-to-one-hot encoder: exactly one output bit is set,
// the one whose index equals the input address.
module onehot_enc #(
  parameter int ADDR_W = 3,
  localparam int OUTS  = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [OUTS-1:0]   onehot_o
);

  // Clear every select line, then raise the addressed one.
  always_comb begin
    onehot_o         = '0;
    onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/addr_decoder_seq.sv
// Sequential address decoder. In IDLE it turns an accepted direct request
// into a one-cycle one-hot strobe; on scan_start it walks an inclusive,
// possibly wrapping address range, one address per enabled cycle.
//
// Handshake: a direct request transfers on a rising edge where req_valid
// and req_ready are both high. req_ready is combinational and depends on
// en, the FSM state and scan_start (a scan start always wins), never on
// req_valid. A request that is not accepted is simply dropped; the
// requester must hold req_valid until it sees req_ready to guarantee it.
module addr_decoder_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  localparam int OUTS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              scan_start,
  input  logic [ADDR_W-1:0] scan_first,
  input  logic [ADDR_W-1:0] scan_last,
  output logic [OUTS-1:0]   y,
  output logic [ADDR_W-1:0] y_addr,
  output logic              y_valid,
  output logic              busy,
  output logic              done,
  output dbg_t              dbg
);

  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   first_q;
  logic [ADDR_W-1:0]   last_q;
  logic [OUTS-1:0]     y_q;
  logic [ADDR_W-1:0]   y_addr_q;
  logic                y_valid_q;
  logic                busy_q;
  logic                done_q;

  logic                req_fire;
  logic                scan_fire;
  logic [ADDR_W-1:0]   enc_addr;
  logic [OUTS-1:0]     enc_y;

  // Acceptance terms: a scan start has priority over a direct request.
  always_comb begin
    req_ready = en && (state_q == ST_IDLE) && !scan_start;
    req_fire  = req_valid && req_ready;
    scan_fire = en && (state_q == ST_IDLE) && scan_start;
  end

  // The single encoder sees the scan counter while scanning, otherwise the
  // direct request address; the register stage decides whether to use it.
  always_comb begin
    enc_addr = req_addr;
    if (state_q == ST_SCAN) begin
      enc_addr = cnt_q;
    end
  end

  onehot_enc #(
    .ADDR_W (ADDR_W)
  ) u_onehot_enc (
    .addr_i   (enc_addr),
    .onehot_o (enc_y)
  );

  // Controller FSM with registered outputs. Outputs default to zero every
  // cycle so y only carries a one-cycle strobe per accepted request or
  // enabled scan step; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      y_q       <= '0;
      y_addr_q  <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      y_q       <= '0;
      y_addr_q  <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (scan_fire) begin
            first_q <= scan_first;
            last_q  <= scan_last;
            cnt_q   <= scan_first;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end else if (req_fire) begin
            y_q       <= enc_y;
            y_addr_q  <= req_addr;
            y_valid_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          // busy stays high through the cycle that shows the last address.
          busy_q <= 1'b1;
          if (en) begin
            y_q       <= enc_y;
            y_addr_q  <= cnt_q;
            y_valid_q <= 1'b1;
            // Natural ADDR_W-bit overflow gives the modulo-OUTS wrap.
            cnt_q     <= cnt_q + CNT_ONE;
            if (cnt_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive ports from the registers and assemble the debug snapshot.
  always_comb begin
    y           = y_q;
    y_addr      = y_addr_q;
    y_valid     = y_valid_q;
    busy        = busy_q;
    done        = done_q;
    dbg         = '0;
    dbg.state   = state_q;
    dbg.cnt     = ADDR_W_MAX'(cnt_q);
    dbg.first   = ADDR_W_MAX'(first_q);
    dbg.last    = ADDR_W_MAX'(last_q);
  end

endmodule

// File: doc/addr_decoder_seq.md
ADDR_DECODER_SEQ -- requirements
Module: addr_decoder_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, address width (range 1..6).
REQ-002 SHALL have derived constant OUTS = 2**ADDR_W, the one-hot output count (8 at default).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, global enable; low suppresses outputs and pauses scan.
REQ-006 SHALL have port req_valid, input, 1, direct-decode request.
REQ-007 SHALL have port req_addr, input, ADDR_W, address for direct decode.
REQ-008 SHALL have port req_ready, output, 1, high when a direct request is accepted this cycle.
REQ-009 SHALL have port scan_start, input, 1, single-cycle pulse starting an auto-scan.
REQ-010 SHALL have ports scan_first and scan_last, input, ADDR_W each, inclusive scan bounds, sampled on accepted scan_start.
REQ-011 SHALL have port y, output, OUTS, registered one-hot select; bit k high selects address k.
REQ-012 SHALL have port y_addr, output, ADDR_W, binary address matching the set bit of y; 0 when y is zero.
REQ-013 SHALL have port y_valid, output, 1, high exactly when y is nonzero.
REQ-014 SHALL have ports busy and done, output, 1 each; busy high during scan, done one-cycle pulse after the last scan address.

Function
REQ-015 SHALL implement FSM states IDLE and SCAN.
REQ-016 SHALL set req_ready = en AND (state == IDLE) AND NOT scan_start, combinationally.
REQ-017 SHALL, in IDLE with req_valid and req_ready, drive y = one-hot(req_addr) for exactly the following cycle (one-cycle strobe, latency 1).
REQ-018 SHALL drive y = 0 in any cycle not produced by an accepted request or active scan step.
REQ-019 SHALL, in IDLE with en and scan_start, latch the bounds, load counter = scan_first, go to SCAN; scan_start wins over a simultaneous req_valid.
REQ-020 SHALL, in SCAN with en high, drive y = one-hot(counter) next cycle and advance counter by 1 modulo OUTS.
REQ-021 SHALL, when the emitted address equals scan_last, return to IDLE and pulse done in the same cycle that address appears on y.
REQ-022 SHALL wrap when scan_last < scan_first (e.g. first=6, last=1 emits 6,7,0,1); first == last emits a single address.
REQ-023 SHALL, in SCAN with en low, hold counter and state and drive y = 0 (pause, no address skipped).
REQ-024 SHALL ignore scan_start and req_valid while in SCAN (req_ready low).
REQ-025 SHALL keep busy high from the cycle after scan_start acceptance through the cycle done pulses, inclusive.
REQ-026 SHALL never assert more than one bit of y in any cycle.

Reset
REQ-027 SHALL, on reset high at a clock edge, force state IDLE, counter 0, latched bounds 0, y 0, y_addr 0, y_valid 0, busy 0, done 0, including mid-scan.
REQ-028 SHALL give reset priority over all other inputs in the same cycle.

Structure
REQ-029 SHALL place the FSM state encoding and the ADDR_W default in shared package regfile_pkg.
REQ-030 SHALL use one sub-module onehot_enc (combinational binary-to-one-hot, parametrised by ADDR_W) feeding the output register.

Verification
REQ-031 SHALL test direct decode: ADDR_W=3, en=1, req_valid=1, req_addr=5 for one cycle -> next cycle y=8'b0010_0000, y_addr=5, y_valid=1; following cycle y=0.
REQ-032 SHALL test plain scan: scan_first=2, scan_last=4, scan_start pulse -> y_addr 2,3,4 on consecutive cycles, done with 4, busy low afterwards.
REQ-033 SHALL test wrap scan: first=6, last=1 -> y_addr 6,7,0,1, done with 1.
REQ-034 SHALL test pause: en low for 2 cycles after address 3 of scan 2..5 -> y=0 for 2 cycles, then 4,5; no skip or repeat.
REQ-035 SHALL test contention: scan_start and req_valid same cycle -> scan runs, request not accepted (req_ready=0); req_valid during SCAN ignored.
REQ-036 SHALL test reset mid-scan: reset at address 3 of scan 0..7 -> next cycle all outputs 0, state IDLE, req_ready high following cycle.
